// File: rtl/display_scanner_1k.sv
// Multiplexed 4-digit 7-segment scanner: advances one digit per clk_k rising edge, with frame snapshot and per-digit blink.
// Latency: outputs registered, update on the clk edge where the clk_k rising edge is first seen; no backpressure (free-running scan).
module display_scanner_1k #(
    parameter int unsigned BLINK_HALF = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_k,
    input  logic [15:0] bcd,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int CW = 10;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);

    logic          clk_k_q;
    logic          tick;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   bcd_snap_q, bcd_snap_d;
    logic [3:0]    dp_snap_q, dp_snap_d;
    logic [3:0]    mask_snap_q, mask_snap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    nibble;
    logic          blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign tick = clk_k & ~clk_k_q;

    always_comb begin
        idx_d       = idx_q;
        bcd_snap_d  = bcd_snap_q;
        dp_snap_d   = dp_snap_q;
        mask_snap_d = mask_snap_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        an_d        = an_q;
        seg_d       = seg_q;
        dp_d        = dp_q;
        nibble      = 4'd0;
        blank       = 1'b0;
        if (tick) begin
            idx_d = idx_q + 2'd1;
            // Wrapping into digit 0 captures a new frame; digit 0 is drawn from it on this same edge.
            if (idx_q == 2'd3) begin
                bcd_snap_d  = bcd;
                dp_snap_d   = dp_in;
                mask_snap_d = blink_mask;
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            case (idx_d)
                2'd0:    nibble = bcd_snap_d[3:0];
                2'd1:    nibble = bcd_snap_d[7:4];
                2'd2:    nibble = bcd_snap_d[11:8];
                default: nibble = bcd_snap_d[15:12];
            endcase
            blank = phase_d & mask_snap_d[idx_d];
            if (blank) begin
                an_d  = 4'b1111;
                seg_d = 7'b1111111;
                dp_d  = 1'b1;
            end else begin
                an_d  = ~(4'b0001 << idx_d);
                seg_d = seg_decode(nibble);
                dp_d  = ~dp_snap_d[idx_d];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_k_q     <= 1'b0;
            idx_q       <= 2'd3;
            bcd_snap_q  <= '0;
            dp_snap_q   <= '0;
            mask_snap_q <= '0;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            an_q        <= 4'b1111;
            seg_q       <= 7'b1111111;
            dp_q        <= 1'b1;
        end else begin
            clk_k_q     <= clk_k;
            idx_q       <= idx_d;
            bcd_snap_q  <= bcd_snap_d;
            dp_snap_q   <= dp_snap_d;
            mask_snap_q <= mask_snap_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_display_scanner_1k.sv
// Bench for display_scanner_1k: frame-level model (tick number -> digit, frame snapshot, blink phase) compared every cycle.
module tb_display_scanner_1k;

    localparam int BH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_k = 1'b0;
    logic [15:0] bcd = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic [3:0]  blink_mask = 4'b0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    display_scanner_1k #(.BLINK_HALF(BH)) dut (
        .clk(clk), .reset(reset), .clk_k(clk_k), .bcd(bcd), .dp_in(dp_in),
        .blink_mask(blink_mask), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [16];
    int         n_tick;
    logic [15:0] m_bcd;
    logic [3:0]  m_dp, m_mask;
    logic [11:0] e_out;
    bit          chk_en = 1'b0;

    task automatic check_v(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n_tick = 0;
        m_bcd  = '0;
        m_dp   = '0;
        m_mask = '0;
        e_out  = {4'b1111, 7'b1111111, 1'b1};
    endtask

    // Tick n (counted from reset) shows digit n%4; a new frame starts on every n%4==0.
    task automatic model_adv();
        int  i;
        int  phase;
        logic [3:0] v;
        i = n_tick % 4;
        if (i == 0) begin
            m_bcd  = bcd;
            m_dp   = dp_in;
            m_mask = blink_mask;
        end
        phase = ((n_tick + 1) / BH) % 2;
        v = m_bcd[4*i +: 4];
        if (phase == 1 && m_mask[i])
            e_out = {4'b1111, 7'b1111111, 1'b1};
        else
            e_out = {~(4'b0001 << i), seg_tab[v], ~m_dp[i]};
        n_tick++;
    endtask

    task automatic do_tick(input int hi);
        @(negedge clk) clk_k = 1'b1;
        @(posedge clk);
        #1 model_adv();
        repeat (hi) @(negedge clk);
        clk_k = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) check_v("outputs_vs_model", {an, seg, dp}, e_out);
    end

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        for (int k = 10; k < 16; k++) seg_tab[k] = 7'b0111111;

        // Reset held with clk_k toggling: outputs must stay blank.
        model_reset();
        #1 chk_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk) clk_k = ~clk_k;
            @(negedge clk);
        end
        check_v("reset_blank", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        @(negedge clk);
        clk_k = 1'b0;
        bcd = 16'h1234; dp_in = 4'b0100; blink_mask = 4'b0000;
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);
        check_v("idle_after_release", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});

        // Scan of 1234 with dp on digit 2, two frames.
        do_tick(1); check_v("scan_d0", {an, seg, dp}, {4'b1110, 7'b0011001, 1'b1});
        do_tick(1); check_v("scan_d1", {an, seg, dp}, {4'b1101, 7'b0110000, 1'b1});
        do_tick(1); check_v("scan_d2", {an, seg, dp}, {4'b1011, 7'b0100100, 1'b0});
        do_tick(1); check_v("scan_d3", {an, seg, dp}, {4'b0111, 7'b1111001, 1'b1});
        do_tick(1); check_v("scan_rep_d0", {an, seg, dp}, {4'b1110, 7'b0011001, 1'b1});
        repeat (3) do_tick(1);

        // Mid-frame input change is held off until the next wrap.
        do_tick(2);
        do_tick(2);
        bcd = 16'h9999;
        do_tick(1); check_v("snap_d2_old", {an, seg, dp}, {4'b1011, 7'b0100100, 1'b0});
        do_tick(1); check_v("snap_d3_old", {an, seg, dp}, {4'b0111, 7'b1111001, 1'b1});
        do_tick(1); check_v("snap_d0_new", {an, seg, dp}, {4'b1110, 7'b0010000, 1'b1});
        do_tick(1); check_v("snap_d1_new", {an, seg, dp}, {4'b1101, 7'b0010000, 1'b1});
        repeat (2) do_tick(1);

        // Invalid BCD codes show a dash.
        bcd = 16'hFA00; dp_in = 4'b0000;
        do_tick(1); check_v("inv_d0", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
        do_tick(1); check_v("inv_d1", {an, seg, dp}, {4'b1101, 7'b1000000, 1'b1});
        do_tick(1); check_v("inv_d2", {an, seg, dp}, {4'b1011, 7'b0111111, 1'b1});
        do_tick(1); check_v("inv_d3", {an, seg, dp}, {4'b0111, 7'b0111111, 1'b1});

        // clk_k stuck high for 10 us: nothing moves after the single tick.
        do_tick(1000);
        check_v("stall_hold", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
        repeat (20) @(negedge clk);
        do_tick(1); check_v("after_stall_d1", {an, seg, dp}, {4'b1101, 7'b1000000, 1'b1});

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_v("async_reset", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        model_reset();
        repeat (3) @(negedge clk);
        bcd = 16'h1234; dp_in = 4'b0000; blink_mask = 4'b0001;
        @(negedge clk) reset = 1'b1;
        repeat (2) @(negedge clk);

        // Blink on digit 0 with half-period of 4 ticks.
        do_tick(1); check_v("blink_t0", {an, seg, dp}, {4'b1110, 7'b0011001, 1'b1});
        repeat (3) do_tick(1);
        do_tick(1); check_v("blink_t4", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        do_tick(1); check_v("blink_t5", {an, seg, dp}, {4'b1101, 7'b0110000, 1'b1});
        repeat (2) do_tick(1);
        do_tick(1); check_v("blink_t8", {an, seg, dp}, {4'b1110, 7'b0011001, 1'b1});
        repeat (7) do_tick(1);
        do_tick(1); check_v("blink_t16", {an, seg, dp}, {4'b1110, 7'b0011001, 1'b1});

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scanner_1k.md
DISPLAY_SCANNER_1K -- requirements
Module: display_scanner_1k

Interface
REQ-001 Parameter: BLINK_HALF, 500, number of clk_k ticks per blink half-period (legal 2..1023).
REQ-002 Port: clk  input  1  system clock, 100 MHz; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; state is cleared while reset=0.
REQ-004 Port: clk_k  input  1  1 kHz level from the upstream frequency divider, synchronous to clk.
REQ-005 Port: bcd  input  16  four BCD digits; digit d = bcd[4d+3:4d], digit 0 rightmost.
REQ-006 Port: dp_in  input  4  decimal point request per digit, active-high.
REQ-007 Port: blink_mask  input  4  per-digit blink enable, active-high.
REQ-008 Port: an  output  4  digit anodes, active-low, registered.
REQ-009 Port: seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 Port: dp  output  1  decimal point, active-low, registered.

Function
REQ-011 The block SHALL register clk_k each cycle (clk_k_q) and form tick = clk_k & ~clk_k_q; exactly one tick per clk_k rising edge.
REQ-012 All outputs, the digit index, the snapshot and the blink state SHALL change only on clock edges where tick=1.
REQ-013 The digit index SHALL advance 0->1->2->3->0 on each tick; on a tick the outputs show the new index.
REQ-014 Exactly one an bit SHALL be low at a time: an = ~(4'b0001 << idx) unless blanked.
REQ-015 On the tick that wraps idx 3->0, bcd, dp_in and blink_mask SHALL be captured into a frame snapshot; digit 0 on that edge uses the same captured values.
REQ-016 Digits 1..3 SHALL be displayed from the snapshot only; input changes mid-frame SHALL NOT appear until the next wrap.
REQ-017 Segment decode SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 BCD codes 10..15 SHALL display a dash: seg=0111111.
REQ-019 dp SHALL equal ~dp_in_snapshot[idx].
REQ-020 Blink counter SHALL count ticks 0..BLINK_HALF-1; on the tick with count=BLINK_HALF-1 it SHALL go to 0 and blink phase SHALL toggle.
REQ-021 When phase=1 and blink_mask_snapshot[idx]=1 the digit SHALL be blanked: an=4'b1111, seg=7'b1111111, dp=1; idx still advances.
REQ-022 If clk_k is held high or low, outputs SHALL hold their last value indefinitely.
REQ-023 Latency: outputs SHALL update on the first clk edge at which clk_k=1 after a cycle with clk_k=0.

Reset
REQ-024 While reset=0: an=4'b1111, seg=7'b1111111, dp=1, idx=3, snapshot=0, blink count=0, phase=0, clk_k_q=0.
REQ-025 The first tick after reset release SHALL wrap idx 3->0, capturing the snapshot and showing digit 0.
REQ-026 Assertion of reset mid-frame SHALL force the REQ-024 values immediately, without waiting for a clock edge.

Verification
REQ-027 Reset: hold reset=0 with clk_k toggling -> an=1111, seg=1111111, dp=1 throughout; after release, first tick -> an=1110.
REQ-028 Scan: bcd=16'h1234, dp_in=0100, blink_mask=0 -> successive ticks give an 1110/seg 0011001, 1101/0110000, 1011/0100100 with dp=0, 0111/1111001; then the sequence repeats.
REQ-029 Snapshot: change bcd from 16'h1234 to 16'h9999 while idx=1 -> digits 2,3 still show 2,1; after the next wrap all digits show 9 (0010000).
REQ-030 Invalid: bcd=16'hFA00 -> digits 3,2 show seg=0111111; digits 1,0 show 1000000.
REQ-031 Blink: BLINK_HALF=4, blink_mask=0001 -> digit 0 is blanked on ticks 4..7 and shown on ticks 0..3 and 8..11; other digits are never blanked.
REQ-032 Stall and edge cases: hold clk_k=1 for 10 us -> no output change; assert reset mid-frame between clock edges -> outputs reach the reset values before the next clk edge.
